// File: rtl/cascade_counter_pkg.sv
// Shared types and helpers for the cascaded modulo counter.
// Every file of the counter imports this package.
package counter_pkg;

   typedef enum logic {CNT_WRAP, CNT_HOLD} cnt_mode_e;

   // A digit's terminal value is RADIX-1 when counting up and 0 when counting down.
   function automatic int unsigned term_value(input int unsigned radix, input logic up);
      return up ? radix - 1 : 0;
   endfunction

endpackage

// File: rtl/cascade_counter_if.sv
// Control and status bundle between a driver and the cascaded counter.
// The count value is packed with digit i in bits [i*DW +: DW].
interface cascade_counter_if #(
   parameter int RADIX  = 10,
   parameter int DIGITS = 2
);
   localparam int DW = $clog2(RADIX);

   logic                    Load;
   logic                    Enable;
   logic                    Up;
   counter_pkg::cnt_mode_e  Mode;
   logic [DIGITS*DW-1:0]    P;
   logic [DIGITS*DW-1:0]    Q;
   logic                    TC;
   logic                    Wrap;
   logic                    Sat;
   logic                    LoadErr;

   modport master (
      output Load, Enable, Up, Mode, P,
      input  Q, TC, Wrap, Sat, LoadErr
   );

   modport slave (
      input  Load, Enable, Up, Mode, P,
      output Q, TC, Wrap, Sat, LoadErr
   );
endinterface

// File: rtl/cascade_counter_digit.sv
// One modulo-RADIX digit of the chain; steps when its carry-in is high
// unless the whole chain is frozen in saturate mode.
module counter_digit
   import counter_pkg::*;
#(
   parameter  int RADIX = 10,
   localparam int DW    = $clog2(RADIX)
) (
   input  logic          CLK,
   input  logic          MR,
   input  logic          Load,
   input  logic [DW-1:0] P,
   input  logic          Enable,
   input  logic          Up,
   input  logic          Freeze,
   output logic [DW-1:0] Q,
   output logic          Term
);

   localparam logic [DW-1:0] TOP = DW'(RADIX - 1);

   assign Term = (Q == DW'(term_value(RADIX, Up)));

   always_ff @(posedge CLK or posedge MR) begin
      if (MR) begin
         Q <= '0;
      end else if (Load) begin
         Q <= P;
      end else if (Enable && !Freeze) begin
         if (Up) begin
            Q <= (Q == TOP) ? '0 : Q + DW'(1);
         end else begin
            Q <= (Q == '0) ? TOP : Q - DW'(1);
         end
      end
   end

endmodule

// File: rtl/cascade_counter.sv
// Multi-digit modulo counter: ripple carry chain across digits, load clamping,
// wrap/saturate handling and the Wrap/Sat/LoadErr status registers.
module cascade_counter
   import counter_pkg::*;
#(
   parameter int RADIX  = 10,
   parameter int DIGITS = 2
) (
   input  logic               CLK,
   input  logic               MR,
   cascade_counter_if.slave   bus
);

   localparam int DW = $clog2(RADIX);

   logic [DIGITS-1:0]    carry;
   logic [DIGITS-1:0]    term;
   logic [DIGITS-1:0]    fieldErr;
   logic [DIGITS*DW-1:0] pClamped;
   logic [DIGITS*DW-1:0] q;
   logic                 tc;
   logic                 freeze;
   logic                 wrapReg;
   logic                 satReg;
   logic                 loadErrReg;

   // Digit i steps only when every lower digit sits at its terminal value.
   always_comb begin
      carry    = '0;
      carry[0] = bus.Enable;
      for (int i = 1; i < DIGITS; i++) begin
         carry[i] = carry[i-1] & term[i-1];
      end
   end

   assign tc     = &term;
   assign freeze = tc && (bus.Mode == CNT_HOLD);

   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      // Widen by one bit so the comparison stays meaningful when RADIX is a power of two.
      assign fieldErr[i] = {1'b0, bus.P[i*DW +: DW]} >= (DW+1)'(RADIX);
      assign pClamped[i*DW +: DW] = fieldErr[i] ? DW'(RADIX - 1) : bus.P[i*DW +: DW];

      counter_digit #(.RADIX(RADIX)) u_digit (
         .CLK    (CLK),
         .MR     (MR),
         .Load   (bus.Load),
         .P      (pClamped[i*DW +: DW]),
         .Enable (carry[i]),
         .Up     (bus.Up),
         .Freeze (freeze),
         .Q      (q[i*DW +: DW]),
         .Term   (term[i])
      );
   end

   always_ff @(posedge CLK or posedge MR) begin
      if (MR) begin
         wrapReg    <= 1'b0;
         satReg     <= 1'b0;
         loadErrReg <= 1'b0;
      end else if (bus.Load) begin
         wrapReg    <= 1'b0;
         satReg     <= 1'b0;
         loadErrReg <= |fieldErr;
      end else if (bus.Enable) begin
         wrapReg    <= tc && (bus.Mode == CNT_WRAP);
         satReg     <= satReg | freeze;
         loadErrReg <= 1'b0;
      end else begin
         wrapReg    <= 1'b0;
         loadErrReg <= 1'b0;
      end
   end

   assign bus.Q       = q;
   assign bus.TC      = tc;
   assign bus.Wrap    = wrapReg;
   assign bus.Sat     = satReg;
   assign bus.LoadErr = loadErrReg;

endmodule

// File: tb/tb_cascade_counter.sv
// Bench for cascade_counter (RADIX=10, DIGITS=2): directed scenarios then random
// traffic, all checked against an integer-valued model of the count.
module tb_cascade_counter;
   import counter_pkg::*;

   localparam int RADIX  = 10;
   localparam int DIGITS = 2;
   localparam int DW     = $clog2(RADIX);
   localparam int N      = RADIX ** DIGITS;

   logic CLK = 1'b0;
   logic MR;

   always #5 CLK = ~CLK;

   cascade_counter_if #(.RADIX(RADIX), .DIGITS(DIGITS)) bus ();

   cascade_counter #(.RADIX(RADIX), .DIGITS(DIGITS)) dut (
      .CLK (CLK),
      .MR  (MR),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;

   int mVal;
   bit mWrap;
   bit mSat;
   bit mErr;

   function automatic logic [DIGITS*DW-1:0] packVal(input int v);
      logic [DIGITS*DW-1:0] r;
      r = '0;
      for (int i = 0; i < DIGITS; i++) begin
         r[i*DW +: DW] = DW'((v / (RADIX ** i)) % RADIX);
      end
      return r;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      mVal  = 0;
      mWrap = 0;
      mSat  = 0;
      mErr  = 0;
   endtask

   // Loads clamp each field, counting is plain integer +/-1 modulo RADIX**DIGITS.
   task automatic modelStep();
      int  v;
      int  f;
      bit  err;
      bit  atEnd;
      if (bus.Load) begin
         v   = 0;
         err = 0;
         for (int i = 0; i < DIGITS; i++) begin
            f = int'(bus.P[i*DW +: DW]);
            if (f >= RADIX) begin
               f   = RADIX - 1;
               err = 1;
            end
            v += f * (RADIX ** i);
         end
         mVal  = v;
         mErr  = err;
         mSat  = 0;
         mWrap = 0;
      end else if (bus.Enable) begin
         atEnd = bus.Up ? (mVal == N - 1) : (mVal == 0);
         mErr  = 0;
         mWrap = 0;
         if (atEnd && bus.Mode == CNT_HOLD) begin
            mSat = 1;
         end else if (atEnd) begin
            mVal  = bus.Up ? 0 : N - 1;
            mWrap = 1;
         end else begin
            mVal = bus.Up ? mVal + 1 : mVal - 1;
         end
      end else begin
         mWrap = 0;
         mErr  = 0;
      end
   endtask

   task automatic checkAll(input string tag);
      bit expTc;
      expTc = bus.Up ? (mVal == N - 1) : (mVal == 0);
      checkOutput({tag, ".Q"},       32'(bus.Q),       32'(packVal(mVal)));
      checkOutput({tag, ".TC"},      32'(bus.TC),      32'(expTc));
      checkOutput({tag, ".Wrap"},    32'(bus.Wrap),    32'(mWrap));
      checkOutput({tag, ".Sat"},     32'(bus.Sat),     32'(mSat));
      checkOutput({tag, ".LoadErr"}, 32'(bus.LoadErr), 32'(mErr));
   endtask

   task automatic applyStimulus(input logic load, input logic en, input logic up,
                                input cnt_mode_e mode, input logic [DIGITS*DW-1:0] p,
                                input string tag);
      bus.Load   = load;
      bus.Enable = en;
      bus.Up     = up;
      bus.Mode   = mode;
      bus.P      = p;
      @(posedge CLK);
      #1;
      modelStep();
      checkAll(tag);
   endtask

   initial begin
      logic      rUp;
      logic      rLoad;
      logic      rEn;
      cnt_mode_e rMode;

      MR         = 1'b1;
      bus.Load   = 1'b0;
      bus.Enable = 1'b0;
      bus.Up     = 1'b0;
      bus.Mode   = CNT_WRAP;
      bus.P      = '0;
      modelReset();
      #12;
      MR = 1'b0;
      checkAll("reset");

      // Asynchronous reset mid-cycle from a loaded value.
      applyStimulus(1, 0, 1, CNT_WRAP, 8'h42, "load42");
      checkOutput("q42", 32'(bus.Q), 32'h42);
      #2 MR = 1'b1;
      #1;
      modelReset();
      checkAll("mr_async");
      checkOutput("mr_q", 32'(bus.Q), 32'h00);
      #5 MR = 1'b0;

      // Full up count to 99 then rollover.
      for (int i = 0; i < 99; i++) begin
         applyStimulus(0, 1, 1, CNT_WRAP, '0, "upcount");
      end
      checkOutput("q99", 32'(bus.Q), 32'h99);
      checkOutput("tc99", 32'(bus.TC), 32'h1);
      applyStimulus(0, 1, 1, CNT_WRAP, '0, "rollover");
      checkOutput("roll_q", 32'(bus.Q), 32'h00);
      checkOutput("roll_wrap", 32'(bus.Wrap), 32'h1);
      applyStimulus(0, 1, 1, CNT_WRAP, '0, "after_roll");
      checkOutput("wrap_once", 32'(bus.Wrap), 32'h0);

      // Load beats enable.
      applyStimulus(1, 1, 1, CNT_WRAP, 8'h07, "load_wins");
      checkOutput("load07", 32'(bus.Q), 32'h07);
      applyStimulus(0, 1, 1, CNT_WRAP, '0, "after_load");
      checkOutput("q08", 32'(bus.Q), 32'h08);

      // Down count into saturation, then load clears Sat.
      applyStimulus(1, 0, 0, CNT_HOLD, 8'h01, "load01");
      applyStimulus(0, 1, 0, CNT_HOLD, '0, "down_to0");
      checkOutput("q00", 32'(bus.Q), 32'h00);
      applyStimulus(0, 1, 0, CNT_HOLD, '0, "hold1");
      checkOutput("sat_set", 32'(bus.Sat), 32'h1);
      applyStimulus(0, 1, 0, CNT_HOLD, '0, "hold2");
      applyStimulus(0, 0, 0, CNT_HOLD, '0, "hold_idle");
      checkOutput("sat_sticky", 32'(bus.Sat), 32'h1);
      applyStimulus(1, 0, 0, CNT_HOLD, 8'h10, "load10");
      checkOutput("sat_clr", 32'(bus.Sat), 32'h0);
      checkOutput("q10", 32'(bus.Q), 32'h10);

      // Out-of-range load is clamped.
      applyStimulus(1, 0, 1, CNT_WRAP, 8'hC5, "loadC5");
      checkOutput("q95", 32'(bus.Q), 32'h95);
      checkOutput("lerr_set", 32'(bus.LoadErr), 32'h1);
      applyStimulus(1, 0, 1, CNT_WRAP, 8'h35, "load35");
      checkOutput("lerr_clr", 32'(bus.LoadErr), 32'h0);

      // Enable dropped mid-count.
      applyStimulus(0, 1, 1, CNT_WRAP, '0, "cnt_a");
      applyStimulus(0, 0, 1, CNT_WRAP, '0, "paused_a");
      applyStimulus(0, 0, 1, CNT_WRAP, '0, "paused_b");
      checkOutput("frozen", 32'(bus.Q), 32'h36);
      applyStimulus(0, 1, 1, CNT_WRAP, '0, "resume");
      checkOutput("resumed", 32'(bus.Q), 32'h37);

      // Direction change at 10 and combinational TC.
      applyStimulus(1, 0, 1, CNT_WRAP, 8'h10, "load10b");
      applyStimulus(0, 1, 0, CNT_WRAP, '0, "down_09");
      checkOutput("q09", 32'(bus.Q), 32'h09);
      applyStimulus(1, 0, 1, CNT_WRAP, 8'h00, "load00");
      checkOutput("tc_up0", 32'(bus.TC), 32'h0);
      bus.Up = 1'b0;
      #1;
      checkOutput("tc_comb", 32'(bus.TC), 32'h1);

      // Random traffic.
      rUp = 1'b1;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(15) == 0) rUp = ~rUp;
         rLoad = ($urandom_range(9) == 0);
         rEn   = ($urandom_range(4) != 0);
         rMode = ($urandom_range(1) == 1) ? CNT_HOLD : CNT_WRAP;
         applyStimulus(rLoad, rEn, rUp, rMode, 8'($urandom), "random");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
